// File: rtl/fft_stream_checker.sv
// Self-checking monitor for the R2MDC FFT/IFFT output stream: compares each
// valid beat against a reference memory addressed here, counting and locating errors.
module fft_stream_checker #(
  parameter int          DATA_W     = 16,
  parameter int          LANES      = 2,
  parameter int          FRAME_LEN  = 32,
  parameter int          NUM_FRAMES = 1000,
  parameter int unsigned TOL        = 0,
  parameter int          ERR_W      = 16,
  localparam int         CYC_W      = $clog2(FRAME_LEN),
  localparam int         FRM_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int         ADDR_W     = $clog2(FRAME_LEN * NUM_FRAMES)
) (
  input  logic                      CLK,
  input  logic                      ARSTN,
  input  logic                      Clear,
  input  logic                      valid_in,
  input  logic [LANES*DATA_W-1:0]   dut_re,
  input  logic [LANES*DATA_W-1:0]   dut_im,
  input  logic [LANES*DATA_W-1:0]   ref_re,
  input  logic [LANES*DATA_W-1:0]   ref_im,
  output logic [ADDR_W-1:0]         ref_addr,
  output logic                      mismatch,
  output logic [LANES-1:0]          lane_fail,
  output logic                      frame_done,
  output logic [ERR_W-1:0]          frame_err,
  output logic [ERR_W-1:0]          err_count,
  output logic                      first_err_valid,
  output logic [FRM_W-1:0]          first_err_frame,
  output logic [CYC_W-1:0]          first_err_cycle,
  output logic [LANES-1:0]          first_err_lanes,
  output logic                      done,
  output logic                      pass
);

  if (FRAME_LEN < 2) begin : g_bad_frame_len
    $error("fft_stream_checker: FRAME_LEN must be >= 2");
  end
  if (NUM_FRAMES < 1) begin : g_bad_num_frames
    $error("fft_stream_checker: NUM_FRAMES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t            state_q, state_d;
  logic              beat;
  logic [CYC_W-1:0]  cyc;
  logic [FRM_W-1:0]  frm;
  logic [ERR_W-1:0]  frame_run;
  logic [ERR_W-1:0]  frame_run_inc;
  logic [LANES-1:0]  lane_fail_c;
  logic              beat_fail;
  logic              last_cyc;
  logic              last_frm;

  // Difference is formed one bit wider than the samples so extreme opposite
  // values cannot alias to a small magnitude.
  function automatic logic comp_fail(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] d;
    logic [DATA_W:0] mag;
    d   = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    mag = d[DATA_W] ? (~d + 1'b1) : d;
    return 64'(mag) > 64'(TOL);
  endfunction

  always_comb begin
    lane_fail_c = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_fail_c[l] = comp_fail(dut_re[l*DATA_W +: DATA_W], ref_re[l*DATA_W +: DATA_W]) ||
                       comp_fail(dut_im[l*DATA_W +: DATA_W], ref_im[l*DATA_W +: DATA_W]);
    end
  end

  assign beat_fail     = |lane_fail_c;
  assign last_cyc      = (cyc == CYC_W'(FRAME_LEN - 1));
  assign last_frm      = (frm == FRM_W'(NUM_FRAMES - 1));
  assign frame_run_inc = (beat_fail && frame_run != ERR_MAX) ? frame_run + 1'b1 : frame_run;
  assign ref_addr      = ADDR_W'(frm) * ADDR_W'(FRAME_LEN) + ADDR_W'(cyc);
  assign pass          = done && (err_count == '0);

  always_ff @(posedge CLK or negedge ARSTN) begin
    if (!ARSTN) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    beat    = 1'b0;
    if (Clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          beat = valid_in;
          if (valid_in) state_d = (last_cyc && last_frm) ? DONE : RUN;
        end
        RUN: begin
          beat = valid_in;
          if (valid_in && last_cyc && last_frm) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ARSTN) begin
    if (!ARSTN) begin
      cyc             <= '0;
      frm             <= '0;
      frame_run       <= '0;
      mismatch        <= 1'b0;
      lane_fail       <= '0;
      frame_done      <= 1'b0;
      frame_err       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_frame <= '0;
      first_err_cycle <= '0;
      first_err_lanes <= '0;
      done            <= 1'b0;
    end else if (Clear) begin
      cyc             <= '0;
      frm             <= '0;
      frame_run       <= '0;
      mismatch        <= 1'b0;
      lane_fail       <= '0;
      frame_done      <= 1'b0;
      frame_err       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_frame <= '0;
      first_err_cycle <= '0;
      first_err_lanes <= '0;
      done            <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      mismatch   <= beat && beat_fail;
      lane_fail  <= beat ? lane_fail_c : '0;
      if (beat) begin
        if (beat_fail && err_count != ERR_MAX) err_count <= err_count + 1'b1;
        if (beat_fail && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_frame <= frm;
          first_err_cycle <= cyc;
          first_err_lanes <= lane_fail_c;
        end
        if (last_cyc) begin
          frame_err  <= frame_run_inc;
          frame_run  <= '0;
          frame_done <= 1'b1;
          // The final beat leaves cyc/frm in place so ref_addr stays on the last address.
          if (last_frm) begin
            done <= 1'b1;
          end else begin
            cyc <= '0;
            frm <= frm + 1'b1;
          end
        end else begin
          cyc       <= cyc + 1'b1;
          frame_run <= frame_run_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_stream_checker.sv
// Directed bench: instance a is the 2x32-beat exact-match checker, instance b a
// short-frame, TOL=2, 4-bit-counter variant for tolerance and saturation cases.
module tb_fft_stream_checker;

  logic        CLK = 1'b0;
  logic        ARSTN;
  logic        Clear;
  logic        valid_in;
  logic [31:0] dut_re, dut_im, ref_re, ref_im;

  logic [5:0]  a_ref_addr;
  logic        a_mismatch, a_frame_done, a_fev, a_done, a_pass;
  logic [1:0]  a_lane_fail, a_fel;
  logic [15:0] a_frame_err, a_err_count;
  logic [0:0]  a_fef;
  logic [4:0]  a_fec;

  logic [4:0]  b_ref_addr;
  logic        b_mismatch, b_frame_done, b_fev, b_done, b_pass;
  logic [1:0]  b_lane_fail, b_fel;
  logic [3:0]  b_frame_err, b_err_count;
  logic [2:0]  b_fef;
  logic [1:0]  b_fec;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fft_stream_checker #(.DATA_W(16), .LANES(2), .FRAME_LEN(32), .NUM_FRAMES(2), .TOL(0), .ERR_W(16)) dut_a (
    .CLK(CLK), .ARSTN(ARSTN), .Clear(Clear), .valid_in(valid_in),
    .dut_re(dut_re), .dut_im(dut_im), .ref_re(ref_re), .ref_im(ref_im),
    .ref_addr(a_ref_addr), .mismatch(a_mismatch), .lane_fail(a_lane_fail),
    .frame_done(a_frame_done), .frame_err(a_frame_err), .err_count(a_err_count),
    .first_err_valid(a_fev), .first_err_frame(a_fef), .first_err_cycle(a_fec),
    .first_err_lanes(a_fel), .done(a_done), .pass(a_pass));

  fft_stream_checker #(.DATA_W(16), .LANES(2), .FRAME_LEN(4), .NUM_FRAMES(6), .TOL(2), .ERR_W(4)) dut_b (
    .CLK(CLK), .ARSTN(ARSTN), .Clear(Clear), .valid_in(valid_in),
    .dut_re(dut_re), .dut_im(dut_im), .ref_re(ref_re), .ref_im(ref_im),
    .ref_addr(b_ref_addr), .mismatch(b_mismatch), .lane_fail(b_lane_fail),
    .frame_done(b_frame_done), .frame_err(b_frame_err), .err_count(b_err_count),
    .first_err_valid(b_fev), .first_err_frame(b_fef), .first_err_cycle(b_fec),
    .first_err_lanes(b_fel), .done(b_done), .pass(b_pass));

  function automatic logic [31:0] pat(input int k);
    logic [15:0] lo, hi;
    lo = 16'(k * 37 + 5);
    hi = 16'(-k * 11 - 3);
    return {hi, lo};
  endfunction

  task automatic drive(input logic v, input logic [31:0] rre, input logic [31:0] rim,
                       input logic [31:0] dre, input logic [31:0] dim);
    @(negedge CLK);
    valid_in = v; ref_re = rre; ref_im = rim; dut_re = dre; dut_im = dim;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_clear();
    @(negedge CLK);
    Clear = 1'b1; valid_in = 1'b0;
    @(posedge CLK);
    #1;
    Clear = 1'b0;
  endtask

  task automatic test_reset();
    ARSTN = 1'b0; Clear = 1'b0; valid_in = 1'b0;
    dut_re = '0; dut_im = '0; ref_re = '0; ref_im = '0;
    #12;
    checks++; if (a_ref_addr !== 6'd0) begin failures++; $display("FAIL reset_a_ref_addr got=%0d exp=0", a_ref_addr); end
    checks++; if ({a_mismatch, a_lane_fail, a_frame_done, a_fev, a_done, a_pass} !== 7'd0) begin failures++; $display("FAIL reset_a_flags got=%b exp=0", {a_mismatch, a_lane_fail, a_frame_done, a_fev, a_done, a_pass}); end
    checks++; if ({a_err_count, a_frame_err} !== 32'd0) begin failures++; $display("FAIL reset_a_counts got=%h exp=0", {a_err_count, a_frame_err}); end
    checks++; if ({b_ref_addr, b_err_count, b_done, b_pass, b_fev} !== 12'd0) begin failures++; $display("FAIL reset_b_state got=%h exp=0", {b_ref_addr, b_err_count, b_done, b_pass, b_fev}); end
    @(negedge CLK);
    ARSTN = 1'b1;
    for (int k = 0; k < 5; k++) drive(1'b1, pat(k), ~pat(k), pat(k), ~pat(k));
    checks++; if (a_ref_addr !== 6'd5) begin failures++; $display("FAIL reset_pre_addr got=%0d exp=5", a_ref_addr); end
    #2 ARSTN = 1'b0;
    #1;
    checks++; if (a_ref_addr !== 6'd0) begin failures++; $display("FAIL reset_async_addr got=%0d exp=0", a_ref_addr); end
    @(negedge CLK);
    ARSTN = 1'b1; valid_in = 1'b0;
  endtask

  task automatic test_clean_frames();
    int fd = 0;
    pulse_clear();
    for (int k = 0; k < 64; k++) begin
      checks++; if (a_ref_addr !== 6'(k)) begin failures++; $display("FAIL clean_ref_addr got=%0d exp=%0d", a_ref_addr, k); end
      drive(1'b1, pat(k), ~pat(k), pat(k), ~pat(k));
      if (a_frame_done) fd++;
      checks++; if (a_frame_done !== (k == 31 || k == 63)) begin failures++; $display("FAIL clean_frame_done beat=%0d got=%b", k, a_frame_done); end
      checks++; if (a_mismatch !== 1'b0) begin failures++; $display("FAIL clean_mismatch beat=%0d got=%b exp=0", k, a_mismatch); end
    end
    checks++; if (fd != 2) begin failures++; $display("FAIL clean_frame_done_count got=%0d exp=2", fd); end
    checks++; if (a_frame_err !== 16'd0) begin failures++; $display("FAIL clean_frame_err got=%0d exp=0", a_frame_err); end
    checks++; if (a_err_count !== 16'd0) begin failures++; $display("FAIL clean_err_count got=%0d exp=0", a_err_count); end
    checks++; if ({a_done, a_pass} !== 2'b11) begin failures++; $display("FAIL clean_done_pass got=%b exp=11", {a_done, a_pass}); end
    checks++; if (a_ref_addr !== 6'd63) begin failures++; $display("FAIL clean_final_addr got=%0d exp=63", a_ref_addr); end
  endtask

  task automatic test_corrupt();
    logic [31:0] dre, dim;
    logic [1:0]  exp_lf;
    pulse_clear();
    for (int k = 0; k < 64; k++) begin
      dre = pat(k); dim = ~pat(k);
      if (k == 5)  dim[31:16] = dim[31:16] + 16'd1;
      if (k == 32) dre[15:0]  = dre[15:0] + 16'd1;
      exp_lf = (k == 5) ? 2'b10 : (k == 32) ? 2'b01 : 2'b00;
      drive(1'b1, pat(k), ~pat(k), dre, dim);
      checks++; if (a_lane_fail !== exp_lf) begin failures++; $display("FAIL corrupt_lane_fail beat=%0d got=%b exp=%b", k, a_lane_fail, exp_lf); end
      checks++; if (a_mismatch !== (exp_lf != 2'b00)) begin failures++; $display("FAIL corrupt_mismatch beat=%0d got=%b", k, a_mismatch); end
      if (k == 31 || k == 63) begin
        checks++; if ({a_frame_done, a_frame_err} !== {1'b1, 16'd1}) begin failures++; $display("FAIL corrupt_frame_err beat=%0d got=%b/%0d exp=1/1", k, a_frame_done, a_frame_err); end
      end
    end
    checks++; if (a_err_count !== 16'd2) begin failures++; $display("FAIL corrupt_err_count got=%0d exp=2", a_err_count); end
    checks++; if ({a_fev, a_fef, a_fec, a_fel} !== {1'b1, 1'b0, 5'd5, 2'b10}) begin failures++; $display("FAIL corrupt_first_err got=%b/%0d/%0d/%b exp=1/0/5/10", a_fev, a_fef, a_fec, a_fel); end
    checks++; if ({a_done, a_pass} !== 2'b10) begin failures++; $display("FAIL corrupt_done_pass got=%b exp=10", {a_done, a_pass}); end
  endtask

  task automatic test_tolerance();
    logic [31:0] t_rre [7] = '{32'hFFCE_0064, 32'hFFCE_0064, 32'hFFCE_0064, 32'hFFCE_0064, 32'hFFCE_0064, 32'hFFCE_0064, 32'hFFCE_0064};
    logic [31:0] t_rim [7] = '{32'hFFF9_0007, 32'hFFF9_0007, 32'hFFF9_0007, 32'h7FFF_0007, 32'hFFF9_8000, 32'hFFF9_0007, 32'hFFF9_0007};
    logic [31:0] t_dre [7] = '{32'hFFD0_0066, 32'hFFCC_0062, 32'hFFCE_0067, 32'hFFCE_0064, 32'hFFCE_0064, 32'hFFCB_0064, 32'hFFCE_0064};
    logic [31:0] t_dim [7] = '{32'hFFFB_0009, 32'hFFF7_0005, 32'hFFF9_0007, 32'h8000_0007, 32'hFFF9_7FFF, 32'hFFF9_0005, 32'hFFF9_0007};
    logic [1:0]  t_exp [7] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    pulse_clear();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, t_rre[i], t_rim[i], t_dre[i], t_dim[i]);
      checks++; if (b_lane_fail !== t_exp[i]) begin failures++; $display("FAIL tol_lane_fail row=%0d got=%b exp=%b", i, b_lane_fail, t_exp[i]); end
      checks++; if (b_mismatch !== (t_exp[i] != 2'b00)) begin failures++; $display("FAIL tol_mismatch row=%0d got=%b", i, b_mismatch); end
      if (i == 3) begin
        checks++; if ({b_frame_done, b_frame_err} !== {1'b1, 4'd2}) begin failures++; $display("FAIL tol_frame_err got=%b/%0d exp=1/2", b_frame_done, b_frame_err); end
      end
    end
    checks++; if (b_err_count !== 4'd4) begin failures++; $display("FAIL tol_err_count got=%0d exp=4", b_err_count); end
    checks++; if ({b_fev, b_fef, b_fec, b_fel} !== {1'b1, 3'd0, 2'd2, 2'b01}) begin failures++; $display("FAIL tol_first_err got=%b/%0d/%0d/%b exp=1/0/2/01", b_fev, b_fef, b_fec, b_fel); end
  endtask

  task automatic test_gaps();
    int n = 0;
    logic [31:0] dre;
    pulse_clear();
    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 0) begin
        dre = pat(n);
        if (n == 9) dre[15:0] = dre[15:0] + 16'd1;
        drive(1'b1, pat(n), ~pat(n), dre, ~pat(n));
        n++;
        checks++; if (a_ref_addr !== 6'(n)) begin failures++; $display("FAIL gap_ref_addr n=%0d got=%0d", n, a_ref_addr); end
        checks++; if (a_frame_done !== (n == 32)) begin failures++; $display("FAIL gap_frame_done n=%0d got=%b", n, a_frame_done); end
        checks++; if (a_mismatch !== (n == 10)) begin failures++; $display("FAIL gap_mismatch n=%0d got=%b", n, a_mismatch); end
      end else begin
        drive(1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if ({a_frame_done, a_mismatch, a_lane_fail} !== 4'd0) begin failures++; $display("FAIL gap_idle_flags n=%0d got=%b exp=0", n, {a_frame_done, a_mismatch, a_lane_fail}); end
      end
    end
    checks++; if ({a_err_count, a_frame_err} !== {16'd1, 16'd1}) begin failures++; $display("FAIL gap_counts got=%0d/%0d exp=1/1", a_err_count, a_frame_err); end
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL gap_done got=%b exp=0", a_done); end
  endtask

  task automatic test_clear_with_valid();
    @(negedge CLK);
    Clear = 1'b1; valid_in = 1'b1;
    ref_re = 32'h0; ref_im = 32'h0; dut_re = 32'h1234_5678; dut_im = 32'h0;
    @(posedge CLK);
    #1;
    Clear = 1'b0;
    checks++; if (a_ref_addr !== 6'd0) begin failures++; $display("FAIL clr_ref_addr got=%0d exp=0", a_ref_addr); end
    checks++; if ({a_err_count, a_frame_err} !== 32'd0) begin failures++; $display("FAIL clr_counts got=%h exp=0", {a_err_count, a_frame_err}); end
    checks++; if ({a_fev, a_mismatch, a_lane_fail, a_frame_done, a_done} !== 6'd0) begin failures++; $display("FAIL clr_flags got=%b exp=0", {a_fev, a_mismatch, a_lane_fail, a_frame_done, a_done}); end
    drive(1'b1, pat(0), ~pat(0), pat(0), ~pat(0));
    checks++; if ({a_ref_addr, a_mismatch} !== {6'd1, 1'b0}) begin failures++; $display("FAIL clr_first_beat got=%0d/%b exp=1/0", a_ref_addr, a_mismatch); end
    drive(1'b1, pat(1), ~pat(1), pat(1) ^ 32'h0001_0000, ~pat(1));
    checks++; if ({a_fev, a_fef, a_fec, a_fel} !== {1'b1, 1'b0, 5'd1, 2'b10}) begin failures++; $display("FAIL clr_first_err got=%b/%0d/%0d/%b exp=1/0/1/10", a_fev, a_fef, a_fec, a_fel); end
  endtask

  task automatic test_saturation();
    logic [31:0] dre;
    pulse_clear();
    for (int k = 0; k < 24; k++) begin
      dre = pat(k);
      if (k < 20) dre[15:0] = dre[15:0] + 16'd3;
      drive(1'b1, pat(k), ~pat(k), dre, ~pat(k));
      if (k == 14 || k == 15) begin
        checks++; if (b_err_count !== 4'd15) begin failures++; $display("FAIL sat_err_count beat=%0d got=%0d exp=15", k, b_err_count); end
      end
      if (k == 19) begin
        checks++; if ({b_frame_done, b_frame_err} !== {1'b1, 4'd4}) begin failures++; $display("FAIL sat_frame_err got=%b/%0d exp=1/4", b_frame_done, b_frame_err); end
      end
    end
    checks++; if ({b_frame_done, b_frame_err, b_done, b_pass} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL sat_end got=%b/%0d/%b/%b exp=1/0/1/0", b_frame_done, b_frame_err, b_done, b_pass); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, pat(k), ~pat(k), ~pat(k), pat(k));
      checks++; if ({b_mismatch, b_lane_fail, b_frame_done} !== 4'd0) begin failures++; $display("FAIL post_done_flags got=%b exp=0", {b_mismatch, b_lane_fail, b_frame_done}); end
      checks++; if ({b_ref_addr, b_err_count, b_frame_err} !== {5'd23, 4'd15, 4'd0}) begin failures++; $display("FAIL post_done_counts got=%0d/%0d/%0d exp=23/15/0", b_ref_addr, b_err_count, b_frame_err); end
      checks++; if ({b_done, b_pass} !== 2'b10) begin failures++; $display("FAIL post_done_status got=%b exp=10", {b_done, b_pass}); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frames();
    test_corrupt();
    test_tolerance();
    test_gaps();
    test_clear_with_valid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_stream_checker.md
Name: fft_stream_checker

Overview:
- Synthesizable, parametrised self-checking block for the FFT/IFFT R2MDC output stream; successor to the fixed 2-lane, 32-cycle, 1000-frame capture-then-compare checking.
- Compares every valid output beat against a reference memory addressed by this block, with optional absolute tolerance.
- Keeps per-frame and total error counts, records the first failure location, and raises done/pass.
- Sits beside any ifft/fft top, on FPGA or emulation, fed by that top's output-valid strobe (start_check).

Parameters:
- DATA_W, 16: width of each signed real/imag sample.
- LANES, 2: complex outputs per cycle (ifft_out0, ifft_out1, ...).
- FRAME_LEN, 32: valid beats per transform frame.
- NUM_FRAMES, 1000: frames checked before done.
- TOL, 0: allowed |dut-ref| per component, unsigned; 0 means exact match.
- ERR_W, 16: width of the error counters.
- Localparams: CYC_W=$clog2(FRAME_LEN), FRM_W=$clog2(NUM_FRAMES), ADDR_W=$clog2(FRAME_LEN*NUM_FRAMES).

Ports:
- CLK  in  1  clock, rising edge.
- ARSTN  in  1  asynchronous active-low reset.
- Clear  in  1  synchronous clear of all counters and status.
- valid_in  in  1  DUT output beat valid (start_check).
- dut_re  in  LANES*DATA_W  DUT real parts; lane 0 in LSBs.
- dut_im  in  LANES*DATA_W  DUT imag parts.
- ref_re  in  LANES*DATA_W  reference real parts, combinational read at ref_addr.
- ref_im  in  LANES*DATA_W  reference imag parts.
- ref_addr  out  ADDR_W  frame*FRAME_LEN+cycle of the current beat.
- mismatch  out  1  registered; the previous valid beat failed.
- lane_fail  out  LANES  registered per-lane fail of the previous beat.
- frame_done  out  1  one-cycle pulse after the last beat of each frame.
- frame_err  out  ERR_W  failing beats in the frame just closed; held until the next frame_done.
- err_count  out  ERR_W  total failing beats, saturating.
- first_err_valid  out  1  a failure has been recorded.
- first_err_frame  out  FRM_W  frame index of the first failure.
- first_err_cycle  out  CYC_W  beat index of the first failure.
- first_err_lanes  out  LANES  lane mask of the first failure.
- done  out  1  all NUM_FRAMES frames checked; sticky.
- pass  out  1  done && err_count==0.

Behaviour:
- Reset (ARSTN=0, async) and Clear=1 (sync): all outputs 0; cyc=0, frm=0; state IDLE. Clear beats valid_in when both are high in the same cycle.
- States:
  - IDLE: go to RUN on the first valid_in; that beat is checked.
  - RUN: count beats and check them.
  - DONE: all valid_in ignored; ref_addr frozen at its final value; leave only on Clear or reset.
- ref_addr = frm*FRAME_LEN+cyc, combinational from registers. Reference data must be valid in the same cycle.
- Compare, per lane and component: d = signed(dut) - signed(ref), computed at DATA_W+1 bits. The component fails if |d| > TOL; a lane fails if re or im fails. The beat fails if any lane fails.
- Latency: mismatch and lane_fail register 1 cycle after the valid beat and clear to 0 on the cycle after a non-valid cycle. Counters update on that same edge.
- Beat counting: cyc increments on each valid_in. On the beat where cyc==FRAME_LEN-1:
  - cyc wraps to 0 and frm increments;
  - frame_err loads the running frame count, including this beat;
  - the running frame count resets to 0;
  - frame_done pulses on the next cycle.
- End of test: the last beat of frame NUM_FRAMES-1 sets done, and state goes to DONE.
- Gaps: valid_in may drop mid-frame; counters hold and there is no timeout.
- err_count and the running frame count saturate at 2^ERR_W-1 and never wrap.
- First error: on the first failing beat, capture frame, cycle and lane mask, and set first_err_valid. Later failures never overwrite the capture.
- Reset mid-frame clears everything; the next valid beat is treated as beat 0 of frame 0.
- Parameter legality: FRAME_LEN ≥ 2 and NUM_FRAMES ≥ 1, checked in simulation with $error. Non-power-of-2 values are legal; wrap is by compare, not overflow.

Test Plan:
1. Reset, then 2 frames, LANES=2, FRAME_LEN=32, dut==ref on every beat -> frame_done pulses twice, frame_err=0; with NUM_FRAMES=2, done=1, pass=1, err_count=0, ref_addr runs 0..63.
2. Corrupt lane 1 imag by +1 at frame 0 beat 5 and lane 0 real at frame 1 beat 0, TOL=0 -> mismatch high 1 cycle after each; err_count=2; first_err = frame 0, cycle 5, lanes 2'b10; frame_err=1 at both frame_done pulses; pass=0.
3. TOL=2, offsets of +2 and -2 on all lanes -> no mismatch; an offset of +3 or of -32768 vs ref 32767 -> fail, with no overflow aliasing.
4. valid_in toggling 1-0-1 across 40 beats -> cyc/frm advance only on valid beats; frame_done occurs exactly after the 32nd valid beat.
5. Clear and valid_in asserted together mid-frame 1 -> all counters 0; the next valid beat gives ref_addr=0.
6. ERR_W=4 with 20 failing beats -> err_count=15, saturated; valid_in after done -> ignored and counters unchanged.
